// File: rtl/tile_playfield_if.sv
// Game-logic access port of the tile playfield: held request, one-cycle ack with old tile value.
interface tile_playfield_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned TILE_W = 8
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [TILE_W-1:0] req_wdata;
    logic              ack;
    logic [TILE_W-1:0] rdata;

    modport master (output req, req_we, req_addr, req_wdata, input ack, rdata);
    modport slave  (input req, req_we, req_addr, req_wdata, output ack, rdata);
endinterface

// File: rtl/tile_playfield.sv
// Tile playfield engine: tile RAM loaded from the map ROM, streamed to the renderer during
// active video, and shared with game logic during blanking. Tracks the number of dot tiles.
module tile_playfield #(
    parameter int unsigned ROWS_LOG2  = 5,
    parameter int unsigned COLS_LOG2  = 5,
    parameter int unsigned TILE_W     = 8,
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned H_ACTIVE   = 480,
    parameter int unsigned DOT_CODE   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         restart,
    input  logic [9:0]                   hpos,
    input  logic [9:0]                   vpos,
    input  logic                         display_on,
    output logic [ROWS_LOG2-1:0]         map_row,
    input  logic [(1<<COLS_LOG2)-1:0]    map_bits,
    output logic                         ready,
    output logic                         tile_valid,
    output logic [TILE_W-1:0]            tile_out,
    tile_playfield_if.slave              bus,
    output logic [ROWS_LOG2+COLS_LOG2:0] dot_count,
    output logic                         all_eaten
);
    localparam int unsigned AW = ROWS_LOG2 + COLS_LOG2;
    localparam int unsigned N  = 1 << AW;
    localparam logic [TILE_W-1:0] DOT     = TILE_W'(DOT_CODE);
    localparam logic [10:0]       H_LIM   = 11'(H_ACTIVE);
    localparam logic [AW:0]       CNT_ONE = 1;

    typedef enum logic [1:0] {StInit, StRun, StRdWait, StRmwWr} state_e;

    state_e            state_q, state_d;
    logic [TILE_W-1:0] mem [N];
    logic [AW-1:0]     addr_q;
    logic              restart_pend_q;

    logic [9:0]        hcell, vcell;
    logic [AW-1:0]     disp_addr;
    logic              unused_cell_bits;
    logic              init_bit;
    logic [TILE_W-1:0] init_val;
    logic [TILE_W-1:0] old_val;
    logic [TILE_W-1:0] disp_val;
    logic              take_restart;
    logic              issue;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [TILE_W-1:0] mem_wdata;

    assign hcell            = hpos >> CELL_SHIFT;
    assign vcell            = vpos >> CELL_SHIFT;
    assign disp_addr        = {vcell[ROWS_LOG2-1:0], hcell[COLS_LOG2-1:0]};
    assign unused_cell_bits = ^{hcell[9:COLS_LOG2], vcell[9:ROWS_LOG2]};

    // Map ROM bitmap has column 0 in the MSB, hence the inverted column index.
    assign map_row  = addr_q[AW-1:COLS_LOG2];
    assign init_bit = map_bits[~addr_q[COLS_LOG2-1:0]];
    assign init_val = {{(TILE_W-1){1'b0}}, init_bit};

    assign old_val  = mem[bus.req_addr];
    assign disp_val = mem[disp_addr];

    assign ready        = (state_q != StInit);
    assign all_eaten    = ready && (dot_count == '0);
    assign take_restart = (state_q == StRun) && (restart || restart_pend_q);
    // Logic access only in blanking; a pending restart wins over a new request.
    assign issue        = (state_q == StRun) && !take_restart && !display_on && bus.req;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StInit;
        else        state_q <= state_d;
    end

    // Next-state logic; the wait states cover the ack cycle so the port stays busy for it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   if (&addr_q) state_d = StRun;
            StRun: begin
                if (take_restart)     state_d = StInit;
                else if (issue)       state_d = bus.req_we ? StRmwWr : StRdWait;
            end
            StRdWait: state_d = StRun;
            StRmwWr:  state_d = StRun;
            default:  state_d = StInit;
        endcase
    end

    // Select the single RAM write: map load in INIT, logic write on an issued RMW.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = init_val;
        if (state_q == StInit) begin
            mem_we = 1'b1;
        end else if (issue && bus.req_we) begin
            mem_we    = 1'b1;
            mem_waddr = bus.req_addr;
            mem_wdata = bus.req_wdata;
        end
    end

    // Tile RAM write port (contents are rebuilt by INIT, so no reset).
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Load counter, dot counter, restart latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q         <= '0;
            restart_pend_q <= 1'b0;
            dot_count      <= '0;
            bus.ack        <= 1'b0;
            bus.rdata      <= '0;
            tile_out       <= '0;
            tile_valid     <= 1'b0;
        end else begin
            bus.ack    <= issue;
            tile_valid <= (state_q == StRun) && display_on && ({1'b0, hpos} < H_LIM);
            if (issue) bus.rdata <= old_val;
            if ((state_q == StRun) && display_on) tile_out <= disp_val;

            if ((state_q == StRdWait || state_q == StRmwWr) && restart) restart_pend_q <= 1'b1;
            else if (state_q == StRun)                                  restart_pend_q <= 1'b0;

            if (take_restart)            addr_q <= '0;
            else if (state_q == StInit)  addr_q <= addr_q + 1'b1;

            if (take_restart) begin
                dot_count <= '0;
            end else if (state_q == StInit) begin
                if (init_val == DOT) dot_count <= dot_count + CNT_ONE;
            end else if (issue && bus.req_we) begin
                if (old_val == DOT && bus.req_wdata != DOT)      dot_count <= dot_count - CNT_ONE;
                else if (old_val != DOT && bus.req_wdata == DOT) dot_count <= dot_count + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_tile_playfield.sv
// Bench for tile_playfield: map ROM model, tile RAM reference model, randomized accesses.
module tb_tile_playfield;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic [4:0]  map_row;
    logic [31:0] map_bits;
    logic        ready;
    logic        tile_valid;
    logic [7:0]  tile_out;
    logic [10:0] dot_count;
    logic        all_eaten;

    logic [31:0] rom [32];
    logic [7:0]  model_mem [1024];
    int errors = 0;
    int checks = 0;

    tile_playfield_if #(.ADDR_W(10), .TILE_W(8)) bus ();

    tile_playfield dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .map_row    (map_row),
        .map_bits   (map_bits),
        .ready      (ready),
        .tile_valid (tile_valid),
        .tile_out   (tile_out),
        .bus        (bus),
        .dot_count  (dot_count),
        .all_eaten  (all_eaten)
    );

    always #5 clk = ~clk;
    assign map_bits = rom[map_row];

    // Reference tile map: row r, column c holds bit (31-c) of ROM row r.
    function automatic void model_load();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                model_mem[r * 32 + c] = {7'd0, rom[r][31 - c]};
    endfunction

    function automatic int model_dots();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (model_mem[i] == 8'd1) n++;
        return n;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 3000);
    endtask

    task automatic do_req(input logic we, input logic [9:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
        bus.req = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.ack && lat < 100);
        rd = bus.rdata;
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, bus.ack, tile_valid, all_eaten} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {ready, bus.ack, tile_valid, all_eaten});
        end
        checks++;
        if ({bus.rdata, tile_out, dot_count, map_row} !== 32'd0) begin
            errors++; $display("FAIL reset_values rdata=%0d tile=%0d dots=%0d row=%0d exp all 0",
                               bus.rdata, tile_out, dot_count, map_row);
        end
        reset = 1'b1;
        wait_ready(n);
        checks++;
        if (n !== 1024) begin errors++; $display("FAIL reset_load_cycles got=%0d exp=1024", n); end
        checks++;
        if (dot_count !== 11'(model_dots())) begin
            errors++; $display("FAIL reset_dot_count got=%0d exp=%0d", dot_count, model_dots());
        end
    endtask

    task automatic test_initial_reads();
        logic [7:0] rd;
        int lat;
        logic [9:0] addrs [3] = '{10'd0, 10'd31, 10'd1};
        foreach (addrs[i]) begin
            do_req(1'b0, addrs[i], 8'd0, rd, lat);
            checks++;
            if (lat !== 1 || rd !== model_mem[addrs[i]]) begin
                errors++; $display("FAIL read_addr%0d got=%0d lat=%0d exp=%0d lat=1",
                                   addrs[i], rd, lat, model_mem[addrs[i]]);
            end
        end
    endtask

    task automatic test_display(input int iters);
        int r, c;
        display_on = 1'b1;
        vpos = 10'd0;
        hpos = 10'($urandom_range(0, 15));
        @(posedge clk); #1;
        checks++;
        if (tile_valid !== 1'b1 || tile_out !== model_mem[0]) begin
            errors++; $display("FAIL disp_origin valid=%0d tile=%0d exp valid=1 tile=%0d",
                               tile_valid, tile_out, model_mem[0]);
        end
        for (int i = 0; i < iters; i++) begin
            hpos = 10'($urandom_range(0, 479));
            vpos = 10'($urandom_range(0, 1023));
            r = (int'(vpos) / 16) % 32;
            c = int'(hpos) / 16;
            @(posedge clk); #1;
            checks++;
            if (tile_valid !== 1'b1 || tile_out !== model_mem[r * 32 + c]) begin
                errors++; $display("FAIL disp_rand h=%0d v=%0d valid=%0d tile=%0d exp valid=1 tile=%0d",
                                   hpos, vpos, tile_valid, tile_out, model_mem[r * 32 + c]);
            end
        end
        hpos = 10'd480;
        @(posedge clk); #1;
        checks++;
        if (tile_valid !== 1'b0) begin errors++; $display("FAIL disp_h480 valid=%0d exp=0", tile_valid); end
        hpos = 10'($urandom_range(481, 1023));
        @(posedge clk); #1;
        checks++;
        if (tile_valid !== 1'b0) begin errors++; $display("FAIL disp_hbeyond valid=%0d exp=0", tile_valid); end
        display_on = 1'b0;
        hpos = 10'd0;
        @(posedge clk); #1;
        checks++;
        if (tile_valid !== 1'b0) begin errors++; $display("FAIL disp_blank valid=%0d exp=0", tile_valid); end
    endtask

    task automatic test_write();
        logic [7:0] rd;
        int lat;
        logic [9:0] addrs [3] = '{10'd0, 10'd5, 10'd5};
        logic [7:0] datas [3] = '{8'd0, 8'd1, 8'd1};
        foreach (addrs[i]) begin
            logic [7:0] exp_old;
            exp_old = model_mem[addrs[i]];
            model_mem[addrs[i]] = datas[i];
            do_req(1'b1, addrs[i], datas[i], rd, lat);
            checks++;
            if (lat !== 1 || rd !== exp_old || dot_count !== 11'(model_dots())) begin
                errors++; $display("FAIL write_%0d lat=%0d old=%0d dots=%0d exp lat=1 old=%0d dots=%0d",
                                   i, lat, rd, dot_count, exp_old, model_dots());
            end
            checks++;
            if (bus.ack !== 1'b0) begin errors++; $display("FAIL write_ack_pulse ack=%0d exp=0", bus.ack); end
        end
    endtask

    task automatic test_random(input int iters);
        logic [7:0] rd, wd, exp_old;
        logic [9:0] a;
        logic       we;
        int lat;
        for (int i = 0; i < iters; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 1023));
            wd = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'($urandom_range(0, 255));
            exp_old = model_mem[a];
            if (we) model_mem[a] = wd;
            do_req(we, a, wd, rd, lat);
            checks++;
            if (lat !== 1 || rd !== exp_old || dot_count !== 11'(model_dots())) begin
                errors++; $display("FAIL rand_%0d we=%0d a=%0d lat=%0d old=%0d dots=%0d exp old=%0d dots=%0d",
                                   i, we, a, lat, rd, dot_count, exp_old, model_dots());
            end
        end
    endtask

    task automatic test_display_block();
        int acks = 0;
        display_on = 1'b1;
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd31; bus.req_wdata = 8'd0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL block_no_ack acks=%0d exp=0", acks); end
        display_on = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ack !== 1'b1 || bus.rdata !== model_mem[31]) begin
            errors++; $display("FAIL block_ack ack=%0d rdata=%0d exp ack=1 rdata=%0d",
                               bus.ack, bus.rdata, model_mem[31]);
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_eaten();
        logic [7:0] rd;
        int lat, n;
        for (int i = 0; i < 1024; i++) begin
            if (model_mem[i] == 8'd1) begin
                model_mem[i] = 8'd0;
                do_req(1'b1, 10'(i), 8'd0, rd, lat);
            end
        end
        checks++;
        if (dot_count !== 11'd0 || all_eaten !== 1'b1) begin
            errors++; $display("FAIL eaten dots=%0d all_eaten=%0d exp 0/1", dot_count, all_eaten);
        end
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        checks++;
        if (ready !== 1'b0 || all_eaten !== 1'b0) begin
            errors++; $display("FAIL restart_enter ready=%0d all_eaten=%0d exp 0/0", ready, all_eaten);
        end
        model_load();
        wait_ready(n);
        checks++;
        if (n !== 1024) begin errors++; $display("FAIL restart_cycles got=%0d exp=1024", n); end
        checks++;
        if (dot_count !== 11'(model_dots()) || all_eaten !== 1'b0) begin
            errors++; $display("FAIL restart_dots dots=%0d all_eaten=%0d exp %0d/0",
                               dot_count, all_eaten, model_dots());
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [7:0] rd, rexp;
        logic [9:0] a;
        int lat, n;
        bus.req = 1'b1; bus.req_we = 1'b1;
        bus.req_addr = 10'($urandom_range(0, 1023)); bus.req_wdata = 8'd1;
        @(posedge clk); #1;
        checks++;
        if (bus.ack !== 1'b1) begin errors++; $display("FAIL rmw_issue ack=%0d exp=1", bus.ack); end
        reset = 1'b0;
        #1;
        checks++;
        if ({ready, bus.ack, tile_valid, all_eaten, bus.rdata, tile_out, dot_count, map_row} !== '0) begin
            errors++; $display("FAIL midrst_outputs ready=%0d ack=%0d valid=%0d rdata=%0d dots=%0d exp all 0",
                               ready, bus.ack, tile_valid, bus.rdata, dot_count);
        end
        bus.req = 1'b0;
        for (int r = 0; r < 32; r++) rom[r] = $urandom;
        model_load();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ready(n);
        checks++;
        if (n !== 1024 || dot_count !== 11'(model_dots())) begin
            errors++; $display("FAIL midrst_reload cycles=%0d dots=%0d exp 1024/%0d", n, dot_count, model_dots());
        end
        for (int i = 0; i < 10; i++) begin
            a = 10'($urandom_range(0, 1023));
            rexp = model_mem[a];
            do_req(1'b0, a, 8'd0, rd, lat);
            checks++;
            if (lat !== 1 || rd !== rexp) begin
                errors++; $display("FAIL midrst_read a=%0d got=%0d lat=%0d exp=%0d", a, rd, lat, rexp);
            end
        end
        test_display(20);
    endtask

    initial begin
        bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int r = 0; r < 32; r++) rom[r] = 32'd0;
        rom[0] = 32'h8000_0001;
        model_load();
        test_reset();
        test_initial_reads();
        test_display(40);
        test_write();
        test_random(40);
        test_display_block();
        test_all_eaten();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
